// File: rtl/mem_slave.sv
// mem_slave: single-port word memory with a post-reset clear sweep.
// After reset the FSM sits in INIT for DEPTH cycles writing zeros to every
// location (busy=1, requests ignored), then moves to IDLE and serves
// one-cycle-latency reads and same-edge writes. Asserting read and write
// together in IDLE is rejected with a one-cycle error pulse.
// Optional feature macro: MEM_SLAVE_PARITY_EN adds a stored even-parity bit
// per word, an inj_par input to corrupt it on write, and a parity_err pulse.
module mem_slave #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_SLAVE_PARITY_EN
  input  logic              inj_par,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rdata_valid,
  output logic              busy,
  output logic              error
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd, wr, bad;

  // Requests only count in IDLE; read+write together is illegal.
  assign rd  = (state == IDLE) && read && !write;
  assign wr  = (state == IDLE) && write && !read;
  assign bad = (state == IDLE) && read && write;

  // State and sweep counter; reset restarts the sweep at location 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: walk the counter through every location, then go IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    case (state)
      INIT: begin
        busy   = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state_nx = IDLE;
      end
      default: ;
    endcase
  end

  // Storage is not reset: it only becomes zero as the sweep visits it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= '0;
      else if (wr)       mem[addr] <= data_in;
    end
  end

  // Registered read data, valid and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      rdata_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      rdata_valid <= rd;
      error       <= bad;
      if (rd) data_out <= mem[addr];
    end
  end

`ifdef MEM_SLAVE_PARITY_EN
  logic par_mem [DEPTH];

  // Parity store: even parity of the written word, optionally inverted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) par_mem[cnt] <= 1'b0;
      else if (wr)       par_mem[addr] <= (^data_in) ^ inj_par;
    end
  end

  // Parity check travels alongside rdata_valid; data is still delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= rd && ((^mem[addr]) != par_mem[addr]);
  end
`endif

endmodule
